data_cache: RTL and testbench
=============================

Name: data_cache

Overview:
Direct-mapped, write-back, write-allocate data cache between the CPU core's MEM-stage memory interface and a slower word-wide main memory with a per-word handshake. Hits complete in the same cycle with no stall. Misses assert stall to the pipeline controller, optionally write back the dirty victim line, then refill the line word by word.

Parameters:
INDEX_WIDTH, 5, log2 of line count (32 lines)
OFFSET_WIDTH, 2, log2 of words per line (4 words)
TAG_WIDTH, 32-INDEX_WIDTH-OFFSET_WIDTH-2, tag bits (derived, 23 by default)

Ports:
clk  in  1  main clock
rst  in  1  synchronous reset, active-high
ren  in  1  core read request (core mem_ren)
wen  in  1  core write request (core mem_wen)
addr  in  32  core byte address; bits [1:0] ignored
din  in  32  core write data (core mem_dout)
dout  out  32  read data to core (core mem_din)
stall  out  1  core must hold its request and freeze the pipeline
mem_cs  out  1  main-memory request valid
mem_we  out  1  main-memory write (1) or read (0)
mem_addr  out  32  word-aligned main-memory address
mem_dout  out  32  write data to main memory
mem_din  in  32  read data from main memory
mem_ack  in  1  one-cycle pulse per completed word; ignored when mem_cs=0
hit_cnt  out  32  hit counter, wraps
miss_cnt  out  32  miss counter, wraps

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Address split: tag=addr[31:31-TAG_WIDTH+1], index=addr[INDEX_WIDTH+OFFSET_WIDTH+1:OFFSET_WIDTH+2], word=addr[OFFSET_WIDTH+1:2].
- Storage per line: valid, dirty, tag, 2^OFFSET_WIDTH data words.
- req = ren|wen. If both are high, the access is treated as a write.
- hit = valid[index] & (tag[index]==tag).
- States: IDLE, BACK, FILL.
- IDLE:
  - Read hit: dout=word combinationally in the same cycle; stall=0.
  - Write hit: the word is written at the clock edge, dirty is set, stall=0.
  - Miss: stall=1 combinationally in the same cycle. Next state is BACK if the victim is valid&dirty, else FILL. The word counter is cleared.
- BACK:
  - mem_cs=1, mem_we=1.
  - mem_addr={victim tag,index,cnt,2'b00}; mem_dout=victim word[cnt].
  - On mem_ack, cnt increments. After the ack of the last word, go to FILL with cnt=0.
- FILL:
  - mem_cs=1, mem_we=0.
  - mem_addr={req tag,index,cnt,2'b00}.
  - On mem_ack, mem_din is written into word[cnt] and cnt increments.
  - After the last ack: valid=1, tag=req tag, dirty=0, go to IDLE. The held request then hits in the following cycle; a write sets dirty at that point.
- stall = (state!=IDLE) | (req & ~hit).
- mem_ack may arrive in the first cycle of mem_cs. mem_addr, mem_we and mem_dout stay stable until ack.
- Outputs in IDLE: mem_cs=0, mem_we=0, mem_addr=0, mem_dout=0.
- dout is 0 when there is no read hit in IDLE.
- miss_cnt increments on every IDLE->BACK/FILL transition.
- hit_cnt increments on an IDLE req&hit cycle, except the cycle immediately after FILL completes. A registered "refill_done" flag suppresses that one count.
- The core holds ren/wen/addr/din stable while stall=1. Behaviour is undefined if it does not.
- Reset (at any state, including mid-BACK/FILL):
  - After the edge: state=IDLE, cnt=0, all valid and dirty bits=0, hit_cnt=miss_cnt=0, refill_done=0.
  - Outputs are then mem_cs=0 and stall=(req&~hit)=req.
  - Dirty data is discarded; a partially filled line stays invalid. Data and tag arrays are not reset.

Decomposition:
- Shared define header: state encodings (IDLE/BACK/FILL) and default INDEX_WIDTH/OFFSET_WIDTH.
- One sub-module, dcache_store: valid/dirty/tag/data arrays.
  - One async read port indexed by index.
  - One sync write port: word write, line meta update, invalidate-all on rst.
- data_cache holds the FSM, counters and address muxing.

Test Plan:
- Cold miss read: rst, then read 0x0000_0100; memory acks each word 1 cycle after cs with data 0xA0..0xA3.
  - Required: stall=1 immediately; FILL addresses 0x100, 0x104, 0x108, 0x10C.
  - Then stall=0, dout=0xA0, miss_cnt=1, hit_cnt=0.
- Read hit: read 0x108.
  - Required: stall=0 the same cycle, dout=0xA2, mem_cs=0, hit_cnt=1.
- Write hit: write 0x104 <- 0xDEADBEEF, then read 0x104.
  - Required: no stall, dout=0xDEADBEEF, mem_cs stays 0, line dirty.
- Conflict miss with writeback: read 0x0000_2100 (index 16, new tag).
  - Required: BACK writes 0x100/0x104/0x108/0x10C with 0xA0/0xDEADBEEF/0xA2/0xA3.
  - Then FILL reads 0x2100..0x210C; miss_cnt=2.
- Slow memory: mem_ack delayed 3 cycles per word.
  - Required: mem_addr and mem_dout held stable, cnt does not advance without ack, total stall = 4×4 cycles plus the final IDLE cycle.
- Reset mid-FILL: assert rst after 2 of 4 words acked, with read 0x100 still held.
  - Required: next cycle state=IDLE, mem_cs=0, counters=0.
  - A subsequent read of 0x100 misses (stall=1) and refills all 4 words.

Source files
------------

// File: rtl/data_cache_pkg.sv
// Shared encodings and default geometry for the direct-mapped data cache.
package data_cache_pkg;
  localparam int INDEX_WIDTH_DEF  = 5;
  localparam int OFFSET_WIDTH_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BACK = 2'd1,
    FILL = 2'd2
  } dc_state_e;
endpackage

// File: rtl/dcache_store.sv
// Line storage: valid/dirty/tag/data arrays with one async read port and one sync write port.
module dcache_store
  import data_cache_pkg::*;
#(
  parameter int INDEX_WIDTH  = INDEX_WIDTH_DEF,
  parameter int OFFSET_WIDTH = OFFSET_WIDTH_DEF,
  parameter int TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH - 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [INDEX_WIDTH-1:0]                 index,
  output logic                                   rd_valid,
  output logic                                   rd_dirty,
  output logic [TAG_WIDTH-1:0]                   rd_tag,
  output logic [(1<<OFFSET_WIDTH)-1:0][31:0]     rd_line,
  input  logic                                   word_we,
  input  logic [OFFSET_WIDTH-1:0]                word_sel,
  input  logic [31:0]                            word_data,
  input  logic                                   meta_we,
  input  logic                                   meta_dirty,
  input  logic [TAG_WIDTH-1:0]                   meta_tag
);
  localparam int LINES = 1 << INDEX_WIDTH;

  logic [LINES-1:0]                       valid_q, dirty_q;
  logic [TAG_WIDTH-1:0]                   tag_q  [LINES];
  logic [(1<<OFFSET_WIDTH)-1:0][31:0]     data_q [LINES];

  // Only the status bits are cleared; stale tags/data are harmless once invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (meta_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= meta_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (meta_we) tag_q[index] <= meta_tag;
    if (word_we) data_q[index][word_sel] <= word_data;
  end

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_line  = data_q[index];
endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate data cache: hit path, miss FSM, stats counters.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int INDEX_WIDTH  = INDEX_WIDTH_DEF,
  parameter int OFFSET_WIDTH = OFFSET_WIDTH_DEF,
  parameter int TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH - 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        stall,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dout,
  input  logic [31:0] mem_din,
  input  logic        mem_ack,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  dc_state_e                          state_q, state_d;
  logic [OFFSET_WIDTH-1:0]            cnt_q, cnt_d, word, word_sel;
  logic [INDEX_WIDTH-1:0]             index;
  logic [TAG_WIDTH-1:0]               req_tag, rd_tag;
  logic [(1<<OFFSET_WIDTH)-1:0][31:0] rd_line;
  logic                               rd_valid, rd_dirty, req, hit, last;
  logic                               word_we, meta_we, meta_dirty;
  logic [31:0]                        word_data;
  logic                               hit_inc, miss_inc, fill_done, refill_done_q;
  logic                               unused_ok;

  assign req_tag   = addr[31 -: TAG_WIDTH];
  assign index     = addr[OFFSET_WIDTH+2 +: INDEX_WIDTH];
  assign word      = addr[2 +: OFFSET_WIDTH];
  assign unused_ok = ^addr[1:0];
  assign req       = ren | wen;
  assign hit       = rd_valid && (rd_tag == req_tag);
  assign last      = &cnt_q;

  dcache_store #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .OFFSET_WIDTH(OFFSET_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .index     (index),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .word_we   (word_we),
    .word_sel  (word_sel),
    .word_data (word_data),
    .meta_we   (meta_we),
    .meta_dirty(meta_dirty),
    .meta_tag  (req_tag)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall      = 1'b0;
    dout       = '0;
    mem_cs     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_dout   = '0;
    word_we    = 1'b0;
    word_sel   = word;
    word_data  = din;
    meta_we    = 1'b0;
    meta_dirty = 1'b0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    fill_done  = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        if (hit) begin
          hit_inc = ~refill_done_q;
          if (wen) begin
            word_we    = 1'b1;
            meta_we    = 1'b1;
            meta_dirty = 1'b1;
          end else begin
            dout = rd_line[word];
          end
        end else begin
          stall    = 1'b1;
          miss_inc = 1'b1;
          cnt_d    = '0;
          state_d  = (rd_valid && rd_dirty) ? BACK : FILL;
        end
      end
      BACK: begin
        stall    = 1'b1;
        mem_cs   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {rd_tag, index, cnt_q, 2'b00};
        mem_dout = rd_line[cnt_q];
        // cnt wraps to zero on the last word, ready for FILL
        if (mem_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (last) state_d = FILL;
        end
      end
      FILL: begin
        stall    = 1'b1;
        mem_cs   = 1'b1;
        mem_addr = {req_tag, index, cnt_q, 2'b00};
        if (mem_ack) begin
          word_we   = 1'b1;
          word_sel  = cnt_q;
          word_data = mem_din;
          cnt_d     = cnt_q + 1'b1;
          if (last) begin
            meta_we   = 1'b1;
            fill_done = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // refill_done keeps the replayed request from being counted as a hit
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
      refill_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      refill_done_q <= fill_done;
      if (hit_inc)  hit_cnt  <= hit_cnt + 32'd1;
      if (miss_inc) miss_cnt <= miss_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: hit vector table plus scoreboarded miss/writeback/reset sequences.
module tb_data_cache;
  logic        clk = 1'b0, rst = 1'b1, ren = 1'b0, wen = 1'b0, mem_ack = 1'b0;
  logic [31:0] addr = '0, din = '0, mem_din = '0;
  logic [31:0] dout, mem_addr, mem_dout, hit_cnt, miss_cnt;
  logic        stall, mem_cs, mem_we;

  data_cache dut (
    .clk(clk), .rst(rst), .ren(ren), .wen(wen), .addr(addr), .din(din),
    .dout(dout), .stall(stall), .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
    .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] a; logic [31:0] d; } txn_t;
  typedef struct { logic r; logic w; logic [31:0] a; logic [31:0] d; logic [31:0] exp_dout; int exp_hits; } vec_t;

  int          n_tests = 0, n_fail = 0;
  txn_t        sbq[$];
  logic [31:0] mm [logic [31:0]];
  vec_t        vt [6];
  int          st;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic acc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    ren = r; wen = w; addr = a; din = d;
    @(negedge clk);
  endtask

  task automatic push_fill(input logic [31:0] base);
    for (int i = 0; i < 4; i++) sbq.push_back('{1'b0, base + 32'(4*i), 32'h0});
  endtask

  task automatic push_back(input logic [31:0] base, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3);
    sbq.push_back('{1'b1, base,          d0});
    sbq.push_back('{1'b1, base + 32'h4,  d1});
    sbq.push_back('{1'b1, base + 32'h8,  d2});
    sbq.push_back('{1'b1, base + 32'hC,  d3});
  endtask

  // Memory responder: ack after dly waiting cycles of mem_cs; entered and left at a negedge
  // (or just after a posedge when ack_limit acks have been given).
  task automatic serve(input int dly, input int ack_limit, output int stalls);
    int w, acks;
    logic [31:0] pa, pd;
    logic pwe;
    txn_t e;
    stalls = 0; w = 0; acks = 0; pa = '0; pd = '0; pwe = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (!stall) return;
      stalls++;
      if (mem_cs) begin
        if (w > 0) begin
          chk("hold_addr", mem_addr, pa);
          chk("hold_we", mem_we, pwe);
          chk("hold_dout", mem_dout, pd);
        end
        pa = mem_addr; pwe = mem_we; pd = mem_dout;
        if (w == dly) begin
          mem_ack = 1'b1;
          if (sbq.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_empty: unexpected access addr %h we %b", mem_addr, mem_we);
          end else begin
            e = sbq.pop_front();
            chk("mem_we", mem_we, e.we);
            chk("mem_addr", mem_addr, e.a);
            if (e.we) chk("mem_dout", mem_dout, e.d);
          end
          if (mem_we) mm[mem_addr] = mem_dout;
          mem_din = mm.exists(mem_addr) ? mm[mem_addr] : ~mem_addr;
          acks++;
          w = 0;
        end else begin
          w++;
        end
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_din = '0;
      if (ack_limit != 0 && acks == ack_limit) return;
      @(negedge clk);
    end
    n_tests++; n_fail++;
    $display("FAIL serve_timeout: stall still %b after 200 cycles", stall);
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b0, 32'h108, 32'h0,        32'hA2,       0};
    vt[1] = '{1'b0, 1'b1, 32'h104, 32'hDEADBEEF, 32'h0,        1};
    vt[2] = '{1'b1, 1'b0, 32'h104, 32'h0,        32'hDEADBEEF, 2};
    vt[3] = '{1'b1, 1'b1, 32'h10C, 32'hA3,       32'h0,        3};
    vt[4] = '{1'b1, 1'b0, 32'h100, 32'h0,        32'hA0,       4};
    vt[5] = '{1'b1, 1'b0, 32'h10F, 32'h0,        32'hA3,       5};
    for (int i = 0; i < 4; i++) begin
      mm[32'h100  + 32'(4*i)] = 32'hA0 + 32'(i);
      mm[32'h2100 + 32'(4*i)] = 32'hB0 + 32'(i);
      mm[32'h200  + 32'(4*i)] = 32'hC0 + 32'(i);
    end

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_cs", mem_cs, 0);
    chk("rst_stall", stall, 0);
    chk("rst_dout", dout, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    @(posedge clk); #1 rst = 1'b0;

    // cold miss
    push_fill(32'h100);
    acc(1'b1, 1'b0, 32'h100, 32'h0);
    chk("cold_stall", stall, 1);
    chk("cold_cs", mem_cs, 0);
    serve(1, 0, st);
    chk("cold_stalls", st, 9);
    chk("cold_dout", dout, 32'hA0);
    chk("cold_miss_cnt", miss_cnt, 1);
    chk("cold_hit_cnt", hit_cnt, 0);
    chk("cold_sb", sbq.size(), 0);

    // hit table
    for (int i = 0; i < 6; i++) begin
      acc(vt[i].r, vt[i].w, vt[i].a, vt[i].d);
      chk($sformatf("vec%0d_stall", i), stall, 0);
      chk($sformatf("vec%0d_cs", i), mem_cs, 0);
      chk($sformatf("vec%0d_dout", i), dout, vt[i].exp_dout);
      chk($sformatf("vec%0d_hits", i), hit_cnt, 32'(vt[i].exp_hits));
    end
    acc(1'b0, 1'b0, 32'h0, 32'h0);
    chk("idle_dout", dout, 0);
    chk("table_hit_cnt", hit_cnt, 6);

    // conflict miss with dirty victim
    push_back(32'h100, 32'hA0, 32'hDEADBEEF, 32'hA2, 32'hA3);
    push_fill(32'h2100);
    acc(1'b1, 1'b0, 32'h2100, 32'h0);
    chk("wb_stall", stall, 1);
    serve(1, 0, st);
    chk("wb_stalls", st, 17);
    chk("wb_dout", dout, 32'hB0);
    chk("wb_miss_cnt", miss_cnt, 2);
    chk("wb_sb", sbq.size(), 0);

    // slow memory, clean fill
    push_fill(32'h200);
    acc(1'b1, 1'b0, 32'h200, 32'h0);
    serve(3, 0, st);
    chk("slow_stalls", st, 17);
    chk("slow_dout", dout, 32'hC0);
    chk("slow_miss_cnt", miss_cnt, 3);

    // clean conflict: written-back word must return from memory
    push_fill(32'h100);
    acc(1'b1, 1'b0, 32'h104, 32'h0);
    serve(1, 0, st);
    chk("back_stalls", st, 9);
    chk("back_dout", dout, 32'hDEADBEEF);
    chk("back_miss_cnt", miss_cnt, 4);
    chk("back_hit_cnt", hit_cnt, 6);
    chk("back_sb", sbq.size(), 0);

    // reset after two of four fill words
    push_fill(32'h400);
    acc(1'b1, 1'b0, 32'h400, 32'h0);
    chk("mid_stall", stall, 1);
    serve(1, 2, st);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_cs", mem_cs, 0);
    chk("mid_rst_stall", stall, 1);
    chk("mid_rst_hit_cnt", hit_cnt, 0);
    chk("mid_rst_miss_cnt", miss_cnt, 0);
    sbq.delete();
    ren = 1'b0; rst = 1'b0;

    // previously valid line is gone; ack in the first cs cycle
    push_fill(32'h100);
    acc(1'b1, 1'b0, 32'h100, 32'h0);
    chk("post_stall", stall, 1);
    serve(0, 0, st);
    chk("post_stalls", st, 5);
    chk("post_dout", dout, 32'hA0);
    chk("post_miss_cnt", miss_cnt, 1);
    chk("post_hit_cnt", hit_cnt, 0);
    chk("post_sb", sbq.size(), 0);
    acc(1'b0, 1'b0, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
